pipe_skid_stage: RTL and testbench

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

---
 rtl/pipe_pkg.sv | 19 +
 rtl/skid_slot.sv | 113 +++++++++++
 rtl/pipe_skid_stage.sv | 98 +++++++++
 tb/tb_pipe_skid_stage.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipe_skid_stage slice.
package pipe_pkg;

    localparam int unsigned PIPE_DATA_W = 32;
    localparam int unsigned PIPE_CNT_W  = 16;

    // Per-slot fill state; the encoding doubles as {skid_valid, main_valid}.
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StMain  = 2'b01,
        StFull  = 2'b11
    } slot_state_e;

    // Width able to hold 0..2*depth valid entries.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(2 * depth + 1);
    endfunction

endpackage

// File: rtl/skid_slot.sv
// skid_slot: one 2-entry (main + skid) register slot with a registered ready.
module skid_slot
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = PIPE_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_fill
);

    slot_state_e       r_state;
    slot_state_e       w_state_d;
    logic              r_ready;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;

    logic w_accept;
    logic w_drain;
    logic w_load_main;
    logic w_main_from_skid;
    logic w_load_skid;

    assign w_accept = i_valid && r_ready;
    assign w_drain  = (r_state != StEmpty) && i_ready;

    always_comb begin
        w_state_d        = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        // Flush wins over any accept; the data registers are left stale.
        if (i_flush) begin
            w_state_d = StEmpty;
        end else begin
            unique case (r_state)
                StEmpty: begin
                    if (w_accept) begin
                        w_state_d   = StMain;
                        w_load_main = 1'b1;
                    end
                end
                StMain: begin
                    if (w_drain && w_accept) begin
                        w_load_main = 1'b1;
                    end else if (w_drain) begin
                        w_state_d = StEmpty;
                    end else if (w_accept) begin
                        w_state_d   = StFull;
                        w_load_skid = 1'b1;
                    end
                end
                StFull: begin
                    // r_ready is low here, so no accept can coincide.
                    if (w_drain) begin
                        w_state_d        = StMain;
                        w_main_from_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_d = StEmpty;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StEmpty;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_d;
            r_ready <= (w_state_d != StFull);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main) begin
                r_main <= i_data;
            end else if (w_main_from_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= i_data;
            end
        end
    end

    assign o_ready = r_ready;
    assign o_valid = (r_state != StEmpty);
    assign o_data  = r_main;

    always_comb begin
        o_fill = 2'd0;
        unique case (r_state)
            StMain:  o_fill = 2'd1;
            StFull:  o_fill = 2'd2;
            default: o_fill = 2'd0;
        endcase
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: DEPTH chained skid slots, registered in_ready, occupancy count.
// Define PIPE_SKID_STATS_EN to add the saturating stall_cnt / bubble_cnt counters.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = PIPE_DATA_W,
    parameter int unsigned DEPTH  = 1,
    parameter int unsigned CNT_W  = PIPE_CNT_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush_i,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic [occ_width(DEPTH)-1:0] occupancy
`ifdef PIPE_SKID_STATS_EN
    ,
    output logic [CNT_W-1:0]            stall_cnt,
    output logic [CNT_W-1:0]            bubble_cnt
`endif
);

    localparam int unsigned OCC_W = occ_width(DEPTH);
    localparam bit ParamsOk = (DATA_W >= 1) && (DATA_W <= 256) && (DEPTH >= 1) &&
                              (DEPTH <= 4) && (CNT_W >= 1);

    if (!ParamsOk) begin : g_bad_params
        $error("pipe_skid_stage: parameter out of legal range");
    end

    // Index i is the boundary feeding slot i; index DEPTH is the downstream port.
    logic              w_valid [DEPTH+1];
    logic              w_ready [DEPTH+1];
    logic [DATA_W-1:0] w_data  [DEPTH+1];
    logic [1:0]        w_fill  [DEPTH];
    logic [OCC_W-1:0]  w_occ;

    assign w_valid[0]     = in_valid;
    assign w_data[0]      = in_data;
    assign w_ready[DEPTH] = out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        skid_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .i_flush (flush_i),
            .i_valid (w_valid[i]),
            .o_ready (w_ready[i]),
            .i_data  (w_data[i]),
            .o_valid (w_valid[i+1]),
            .i_ready (w_ready[i+1]),
            .o_data  (w_data[i+1]),
            .o_fill  (w_fill[i])
        );
    end

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ = w_occ + OCC_W'(w_fill[i]);
        end
    end

    assign in_ready  = w_ready[0];
    assign out_valid = w_valid[DEPTH];
    assign out_data  = w_data[DEPTH];
    assign occupancy = w_occ;

`ifdef PIPE_SKID_STATS_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    // Counters saturate and ignore flush; only rst clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (!out_valid && out_ready && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage (DEPTH=2); stats checks run when
// PIPE_SKID_STATS_EN is defined.
`timescale 1ns/1ps
module tb_pipe_skid_stage;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned OCC_W  = $clog2(2 * DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush_i = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [OCC_W-1:0]  occupancy;
`ifdef PIPE_SKID_STATS_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] exp_q [$];

    pipe_skid_stage #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (flush_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef PIPE_SKID_STATS_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: the queue holds every accepted, not yet delivered word, so its
    // size must also match occupancy.
    always @(negedge clk) begin
        if (!rst) begin
            check("sb_occupancy", longint'(occupancy), longint'(exp_q.size()));
            check("sb_occ_bound", longint'(occupancy <= OCC_W'(2 * DEPTH)), 1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got 0x%0h, expected no output at %0t",
                             out_data, $time);
                end else begin
                    check("sb_data", longint'(out_data), longint'(exp_q.pop_front()));
                end
            end
            if (flush_i) begin
                exp_q.delete();
            end else if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    logic [DATA_W-1:0] tv [3];
    int                n;
    int                k;
    logic [DATA_W-1:0] rnd_ctr;

    initial begin
        tv[0] = 16'h0011;
        tv[1] = 16'h0022;
        tv[2] = 16'h0033;

        // Reset state, sampled while rst is held.
        tick();
        tick();
        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_occupancy", longint'(occupancy), 0);
        check("rst_out_data", longint'(out_data), 0);
`ifdef PIPE_SKID_STATS_EN
        check("rst_stall_cnt", longint'(stall_cnt), 0);
        check("rst_bubble_cnt", longint'(bubble_cnt), 0);
`endif
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", longint'(in_ready), 1);

        // Back-to-back stream: words appear DEPTH cycles later with no gap.
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c < 3) begin
                in_valid = 1'b1;
                in_data  = tv[c];
            end else begin
                in_valid = 1'b0;
            end
            check("stream_in_ready", longint'(in_ready), 1);
            if (c >= DEPTH && c < DEPTH + 3) begin
                check("stream_valid", longint'(out_valid), 1);
                check("stream_data", longint'(out_data), longint'(tv[c-DEPTH]));
            end else begin
                check("stream_valid", longint'(out_valid), 0);
            end
            tick();
        end

        // Fill with downstream stalled: exactly 2*DEPTH words fit.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h00A0;
        n = 0;
        while (in_ready && n < 20) begin
            tick();
            n++;
            in_data = DATA_W'(16'h00A0 + n);
        end
        check("fill_count", longint'(n), 4);
        check("fill_occupancy", longint'(occupancy), 4);
        in_data = 16'h00EE;
        for (int c = 0; c < 3; c++) begin
            check("full_in_ready", longint'(in_ready), 0);
            check("hold_valid", longint'(out_valid), 1);
            check("hold_data", longint'(out_data), 16'h00A0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while (occupancy != 0 && k < 10) begin
            tick();
            k++;
        end
        check("drain_cycles", longint'(k), 4);
        check("drain_in_ready", longint'(in_ready), 1);

        // Flush with in_ready=1: the coincident in-side word is discarded.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_data = DATA_W'(16'h00B0 + c);
            tick();
        end
        check("pre_flush_occ", longint'(occupancy), 3);
        check("pre_flush_ready", longint'(in_ready), 1);
        flush_i = 1'b1;
        in_data = 16'h00CC;
        check("flush_cycle_ready", longint'(in_ready), 1);
        tick();
        flush_i  = 1'b0;
        in_valid = 1'b0;
        check("flush_occ", longint'(occupancy), 0);
        check("flush_out_valid", longint'(out_valid), 0);
        check("flush_in_ready", longint'(in_ready), 1);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check("post_flush_idle", longint'(out_valid), 0);
            tick();
        end

        // Flush when full: in_ready stays low in the flush cycle, rises after.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h00D0;
        n = 0;
        while (in_ready && n < 20) begin
            tick();
            n++;
            in_data = DATA_W'(16'h00D0 + n);
        end
        check("refill_count", longint'(n), 4);
        flush_i = 1'b1;
        in_data = 16'h00CC;
        check("full_flush_ready", longint'(in_ready), 0);
        tick();
        flush_i  = 1'b0;
        in_valid = 1'b0;
        check("full_flush_after_ready", longint'(in_ready), 1);
        check("full_flush_occ", longint'(occupancy), 0);
        check("full_flush_valid", longint'(out_valid), 0);
        check("stale_out_data", longint'(out_data), 16'h00D0);

        // Asynchronous reset between edges with two entries held.
        in_valid = 1'b1;
        in_data  = 16'h00E0;
        tick();
        in_data = 16'h00E1;
        tick();
        in_valid = 1'b0;
        check("pre_rst_occ", longint'(occupancy), 2);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("async_rst_valid", longint'(out_valid), 0);
        check("async_rst_occ", longint'(occupancy), 0);
        check("async_rst_ready", longint'(in_ready), 1);
        check("async_rst_data", longint'(out_data), 0);
        #2;
        rst = 1'b0;
        tick();
        check("after_rst_valid", longint'(out_valid), 0);

`ifdef PIPE_SKID_STATS_EN
        check("stats_clr_stall", longint'(stall_cnt), 0);
        check("stats_clr_bubble", longint'(bubble_cnt), 0);
        in_valid = 1'b1;
        in_data  = 16'h00F0;
        tick();
        in_valid = 1'b0;
        repeat (25) tick();
        check("stall_saturated", longint'(stall_cnt), 15);
        check("bubble_during_stall", longint'(bubble_cnt), 0);
        out_ready = 1'b1;
        tick();
        check("stats_drained", longint'(out_valid), 0);
        repeat (5) tick();
        check("bubble_count", longint'(bubble_cnt), 5);
        check("stall_hold", longint'(stall_cnt), 15);
        out_ready = 1'b0;
        flush_i   = 1'b1;
        tick();
        flush_i = 1'b0;
        check("flush_keeps_stall", longint'(stall_cnt), 15);
        check("flush_keeps_bubble", longint'(bubble_cnt), 5);
`endif

        // Random valid/ready/flush traffic; the monitor checks order and count.
        rnd_ctr = 16'h1000;
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_data   = rnd_ctr;
            rnd_ctr   = rnd_ctr + 16'd1;
            out_ready = ($urandom_range(0, 99) < ((i < 1500) ? 40 : 80));
            flush_i   = ($urandom_range(0, 199) == 0);
            tick();
        end
        flush_i   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while (exp_q.size() != 0 && k < 50) begin
            tick();
            k++;
        end
        tick();
        check("final_drain", longint'(exp_q.size()), 0);
        check("final_occupancy", longint'(occupancy), 0);
        check("final_out_valid", longint'(out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
